jtag_bus_bridge: RTL and testbench
==================================

// Module: jtag_bus_bridge
// PURPOSE
//  Consumes the JTAG TAP user outputs (userOp/userOp_ready/userData_out) and executes 32-bit
//  system-bus transactions from them. Crosses from tck to clk via a toggle req/ack handshake.
//  Returns read data and status to the TAP through userData_in.
// PARAMETERS
//  ADDR_W       32    bus address width (address reg loaded from userData_out[ADDR_W-1:0])
//  TIMEOUT_CYC  255   clk cycles to wait for bus_ack before forced completion with error
//  ADDR_INC     4     address increment applied by *_INC opcodes
// PORTS
//  tck            in   1       JTAG clock
//  trst           in   1       reset, asynchronous, active-low (resets both domains)
//  clk            in   1       system bus clock
//  userOp         in   8       opcode from TAP USEROP register
//  userOp_ready   in   1       1-tck pulse, userOp/userData_out valid when high
//  userData_out   in   32      operand from TAP USERDATA register
//  userData_in    out  32      capture value for TAP USERDATA register (tck domain)
//  busy           out  1       tck domain: command in flight
//  bus_req        out  1       clk: transaction request, held until ack/timeout
//  bus_we         out  1       clk: 1=write, 0=read
//  bus_addr       out  ADDR_W  clk: address, stable while bus_req
//  bus_wdata      out  32      clk: write data, stable while bus_req
//  bus_ack        in   1       clk: 1-cycle completion strobe
//  bus_rdata      in   32      clk: read data, valid with bus_ack
//  bus_err        in   1       clk: slave error, valid with bus_ack
// BEHAVIOUR
//  Opcodes: 01 SET_ADDR, 02 WRITE, 03 READ, 04 WRITE_INC, 05 READ_INC, 06 CLR_STATUS,
//    07 SEL_STATUS, 08 SEL_DATA; others = NOP (ignored, no status change).
//  tck domain, sampled on posedge tck when userOp_ready=1:
//   - SET_ADDR/CLR_STATUS/SEL_*: take effect same edge, never busy.
//   - bus op with busy=0: latch addr/wdata/we, flip req_tgl, busy<=1.
//   - bus op with busy=1: dropped, sticky overrun<=1.
//  clk domain: req_tgl -> 2FF sync -> edge detect; FSM IDLE->REQ->IDLE.
//   - IDLE: on detected edge, bus_req<=1 (3rd clk posedge after req_tgl change).
//   - REQ: on bus_ack: capture rdata (reads only), err<=bus_err, bus_req<=0, flip ack_tgl.
//     Timeout counter hits TIMEOUT_CYC with no ack: same exit, err<=1, rdata<=32'hDEAD_BEEF.
//     bus_ack in IDLE ignored.
//  ack_tgl -> 2FF sync in tck. When synced ack==req_tgl: busy<=0, rdata/err copied to tck
//   regs (stable across CDC by handshake), *_INC adds ADDR_INC to addr (wraps mod 2^ADDR_W).
//   Completion needs tck running; busy stays 1 while tck stopped.
//  userData_op arriving same edge busy clears: treated as not busy (accepted).
//  Status word {29'b0, err_sticky, overrun_sticky, busy}; err_sticky set by any errored op,
//   cleared only by CLR_STATUS or trst. CLR_STATUS same edge as completion with err: err wins.
//  userData_in = sel_status ? status : rdata_tck. sel_status reset 0.
//  Reset (trst=0): all tck regs 0 (addr 0, busy 0, rdata 0). clk reset asserts async with
//   trst, deasserts after 2 clk posedges; bus_req/bus_we/bus_addr/bus_wdata 0.
//   Reset mid-transaction aborts; bus_req drops immediately (slave must tolerate abort).
// STRUCTURE
//  jtag_bridge_pkg: opcode localparams, status bit indices, DEAD_BEEF fill constant.
//  Sub-module jtag_sync2 (2-flop synchronizer with async clear): req, ack, reset-release.
//  Top holds tck command regs, clk FSM + timeout counter, output mux.
// TESTING
//  SET_ADDR 0x1000, WRITE 0xA5A5_0001 -> one bus_req, we=1, addr 0x1000, wdata match; busy 1->0.
//  READ_INC x2 from 0x2000, slave returns 0x11,0x22 -> addrs 0x2000,0x2004; userData_in=0x22.
//  Second READ while busy -> only one bus_req; SEL_STATUS shows overrun=1; CLR_STATUS -> 0.
//  No bus_ack -> bus_req drops after 255 clk; status err=1; userData_in(SEL_DATA)=0xDEADBEEF.
//  trst low during REQ -> bus_req 0 async; busy 0; next WRITE completes normally.
//  tck:clk ratios 1:7, 7:1, asynchronous phase sweep -> no lost/duplicated transactions.

Source files
------------

// File: rtl/jtag_bridge_pkg.sv
// Shared definitions for the JTAG-to-system-bus bridge: opcodes, status bit
// positions, timeout fill pattern and the clk-domain FSM state type.
package jtag_bridge_pkg;

  localparam logic [7:0] OP_SET_ADDR   = 8'h01;
  localparam logic [7:0] OP_WRITE      = 8'h02;
  localparam logic [7:0] OP_READ       = 8'h03;
  localparam logic [7:0] OP_WRITE_INC  = 8'h04;
  localparam logic [7:0] OP_READ_INC   = 8'h05;
  localparam logic [7:0] OP_CLR_STATUS = 8'h06;
  localparam logic [7:0] OP_SEL_STATUS = 8'h07;
  localparam logic [7:0] OP_SEL_DATA   = 8'h08;

  localparam int ST_BUSY    = 0;
  localparam int ST_OVERRUN = 1;
  localparam int ST_ERR     = 2;

  localparam logic [31:0] FILL_DEAD_BEEF = 32'hDEAD_BEEF;

  typedef enum logic [0:0] {
    BUS_IDLE = 1'b0,
    BUS_REQ  = 1'b1
  } bus_state_e;

  // True for opcodes that write the bus.
  function automatic logic op_is_write(input logic [7:0] op);
    return (op == OP_WRITE) || (op == OP_WRITE_INC);
  endfunction

  // True for opcodes that post-increment the address on completion.
  function automatic logic op_is_inc(input logic [7:0] op);
    return (op == OP_WRITE_INC) || (op == OP_READ_INC);
  endfunction

endpackage

// File: rtl/jtag_sync2.sv
// Two-flop synchronizer with asynchronous active-low clear.
module jtag_sync2 (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Two-stage capture of an asynchronous level into the clk domain.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/jtag_bus_bridge.sv
// Executes 32-bit bus transactions requested through the JTAG TAP user
// registers. Commands are captured in tck, handed to clk with a toggle
// req/ack handshake, and results are returned via userData_in.
module jtag_bus_bridge
  import jtag_bridge_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255,
  parameter int ADDR_INC    = 4
) (
  input  logic              tck,
  input  logic              trst,
  input  logic              clk,
  input  logic [7:0]        userOp,
  input  logic              userOp_ready,
  input  logic [31:0]       userData_out,
  output logic [31:0]       userData_in,
  output logic              busy,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata,
  input  logic              bus_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  // tck-domain command and status registers
  logic [ADDR_W-1:0] addr_r, cmd_addr_r;
  logic [31:0]       cmd_wdata_r, rdata_tck_r;
  logic              cmd_we_r, inc_r, req_tgl_r, busy_r;
  logic              overrun_r, err_sticky_r, sel_status_r;
  logic              ack_sync_s, done_s, accept_ok_s;
  logic [ADDR_W-1:0] addr_adv_s;

  // clk-domain registers
  bus_state_e        state_r, state_nxt_s;
  logic              rst_clk_n_s, req_sync_s, req_prev_r, req_edge_s;
  logic              ack_tgl_r, ack_tgl_nxt_s, err_clk_r, err_clk_nxt_s;
  logic [31:0]       rdata_clk_r, rdata_clk_nxt_s;
  logic [TMO_W-1:0]  tmo_cnt_r, tmo_cnt_nxt_s;
  logic              bus_req_nxt_s, bus_we_nxt_s;
  logic [ADDR_W-1:0] bus_addr_nxt_s;
  logic [31:0]       bus_wdata_nxt_s;

  jtag_sync2 u_sync_rst (.clk(clk), .clr_n(trst),        .d(1'b1),      .q(rst_clk_n_s));
  jtag_sync2 u_sync_req (.clk(clk), .clr_n(rst_clk_n_s), .d(req_tgl_r), .q(req_sync_s));
  jtag_sync2 u_sync_ack (.clk(tck), .clr_n(trst),        .d(ack_tgl_r), .q(ack_sync_s));

  // Completion is seen when the returned ack toggle catches up with req.
  assign done_s      = busy_r & (ack_sync_s == req_tgl_r);
  assign accept_ok_s = ~busy_r | done_s;
  assign addr_adv_s  = (done_s & inc_r) ? addr_r + ADDR_W'(ADDR_INC) : addr_r;

  // tck domain: decode TAP opcodes, launch bus ops, collect completions.
  always_ff @(posedge tck or negedge trst) begin
    if (!trst) begin
      addr_r       <= '0;
      cmd_addr_r   <= '0;
      cmd_wdata_r  <= 32'h0;
      rdata_tck_r  <= 32'h0;
      cmd_we_r     <= 1'b0;
      inc_r        <= 1'b0;
      req_tgl_r    <= 1'b0;
      busy_r       <= 1'b0;
      overrun_r    <= 1'b0;
      err_sticky_r <= 1'b0;
      sel_status_r <= 1'b0;
    end else begin
      addr_r <= addr_adv_s;
      if (done_s) begin
        busy_r      <= 1'b0;
        rdata_tck_r <= rdata_clk_r;
      end
      if (userOp_ready) begin
        case (userOp)
          OP_SET_ADDR:   addr_r <= userData_out[ADDR_W-1:0];
          OP_CLR_STATUS: begin
            err_sticky_r <= 1'b0;
            overrun_r    <= 1'b0;
          end
          OP_SEL_STATUS: sel_status_r <= 1'b1;
          OP_SEL_DATA:   sel_status_r <= 1'b0;
          OP_WRITE, OP_READ, OP_WRITE_INC, OP_READ_INC: begin
            if (accept_ok_s) begin
              cmd_addr_r  <= addr_adv_s;
              cmd_wdata_r <= userData_out;
              cmd_we_r    <= op_is_write(userOp);
              inc_r       <= op_is_inc(userOp);
              req_tgl_r   <= ~req_tgl_r;
              busy_r      <= 1'b1;
            end else begin
              overrun_r   <= 1'b1;
            end
          end
          default: begin
          end
        endcase
      end
      // An error completing on the same edge as CLR_STATUS must survive.
      if (done_s && err_clk_r) begin
        err_sticky_r <= 1'b1;
      end
    end
  end

  assign busy        = busy_r;
  assign userData_in = sel_status_r
                     ? {29'b0, err_sticky_r, overrun_r, busy_r}
                     : rdata_tck_r;

  assign req_edge_s = req_sync_s ^ req_prev_r;

  // clk domain: next-state and registered bus outputs.
  always_comb begin
    state_nxt_s     = state_r;
    bus_req_nxt_s   = bus_req;
    bus_we_nxt_s    = bus_we;
    bus_addr_nxt_s  = bus_addr;
    bus_wdata_nxt_s = bus_wdata;
    ack_tgl_nxt_s   = ack_tgl_r;
    err_clk_nxt_s   = err_clk_r;
    rdata_clk_nxt_s = rdata_clk_r;
    tmo_cnt_nxt_s   = tmo_cnt_r;
    case (state_r)
      BUS_IDLE: begin
        if (req_edge_s) begin
          state_nxt_s     = BUS_REQ;
          bus_req_nxt_s   = 1'b1;
          bus_we_nxt_s    = cmd_we_r;
          bus_addr_nxt_s  = cmd_addr_r;
          bus_wdata_nxt_s = cmd_wdata_r;
          tmo_cnt_nxt_s   = '0;
        end else begin
          state_nxt_s     = BUS_IDLE;
        end
      end
      BUS_REQ: begin
        if (bus_ack) begin
          state_nxt_s   = BUS_IDLE;
          bus_req_nxt_s = 1'b0;
          err_clk_nxt_s = bus_err;
          ack_tgl_nxt_s = ~ack_tgl_r;
          if (!bus_we) begin
            rdata_clk_nxt_s = bus_rdata;
          end else begin
            rdata_clk_nxt_s = rdata_clk_r;
          end
        end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_nxt_s     = BUS_IDLE;
          bus_req_nxt_s   = 1'b0;
          err_clk_nxt_s   = 1'b1;
          rdata_clk_nxt_s = FILL_DEAD_BEEF;
          ack_tgl_nxt_s   = ~ack_tgl_r;
        end else begin
          tmo_cnt_nxt_s   = tmo_cnt_r + TMO_W'(1);
        end
      end
      default: state_nxt_s = BUS_IDLE;
    endcase
  end

  // clk domain: state and output registers, cleared asynchronously with trst.
  always_ff @(posedge clk or negedge rst_clk_n_s) begin
    if (!rst_clk_n_s) begin
      state_r     <= BUS_IDLE;
      req_prev_r  <= 1'b0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= '0;
      bus_wdata   <= 32'h0;
      ack_tgl_r   <= 1'b0;
      err_clk_r   <= 1'b0;
      rdata_clk_r <= 32'h0;
      tmo_cnt_r   <= '0;
    end else begin
      state_r     <= state_nxt_s;
      req_prev_r  <= req_sync_s;
      bus_req     <= bus_req_nxt_s;
      bus_we      <= bus_we_nxt_s;
      bus_addr    <= bus_addr_nxt_s;
      bus_wdata   <= bus_wdata_nxt_s;
      ack_tgl_r   <= ack_tgl_nxt_s;
      err_clk_r   <= err_clk_nxt_s;
      rdata_clk_r <= rdata_clk_nxt_s;
      tmo_cnt_r   <= tmo_cnt_nxt_s;
    end
  end

endmodule

// File: tb/tb_jtag_bus_bridge.sv
// Directed bench for jtag_bus_bridge: command sequencing, auto-increment,
// overrun, timeout, slave error, reset abort and clock-ratio sweep.
module tb_jtag_bus_bridge;
  import jtag_bridge_pkg::*;

  logic        tck = 1'b0, clk = 1'b0, trst = 1'b1;
  logic [7:0]  userOp = 8'h00;
  logic        userOp_ready = 1'b0;
  logic [31:0] userData_out = 32'h0;
  logic [31:0] userData_in;
  logic        busy, bus_req, bus_we, bus_ack, bus_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int tck_half = 10;
  int clk_half = 7;

  int n_cmp = 0;
  int n_err = 0;

  // slave model controls
  logic        slave_en = 1'b1;
  logic        slave_err = 1'b0;
  logic [31:0] slave_rdata = 32'h0;
  int          lat = 0;

  // bus monitor
  int          n_req = 0;
  int          req_cycles = 0;
  logic        req_q = 1'b0;
  logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
  logic        last_we = 1'b0;

  jtag_bus_bridge dut (
    .tck(tck), .trst(trst), .clk(clk),
    .userOp(userOp), .userOp_ready(userOp_ready), .userData_out(userData_out),
    .userData_in(userData_in), .busy(busy),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #(tck_half) tck = ~tck;
  always #(clk_half) clk = ~clk;

  // Slave: acknowledges a request after three cycles of bus_req.
  always @(posedge clk or negedge trst) begin
    if (!trst) begin
      bus_ack   <= 1'b0;
      bus_rdata <= 32'h0;
      bus_err   <= 1'b0;
      lat       <= 0;
    end else begin
      bus_ack <= 1'b0;
      if (bus_req && !bus_ack && slave_en) begin
        if (lat == 2) begin
          bus_ack   <= 1'b1;
          bus_rdata <= slave_rdata;
          bus_err   <= slave_err;
          lat       <= 0;
        end else begin
          lat <= lat + 1;
        end
      end else begin
        lat <= 0;
      end
    end
  end

  // Monitor: counts request starts and request-high cycles.
  always @(posedge clk) begin
    req_q <= bus_req;
    if (bus_req === 1'b1) req_cycles <= req_cycles + 1;
    if (bus_req === 1'b1 && req_q !== 1'b1) begin
      n_req      <= n_req + 1;
      last_addr  <= bus_addr;
      last_wdata <= bus_wdata;
      last_we    <= bus_we;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] op, input logic [31:0] d);
    @(negedge tck);
    userOp       = op;
    userData_out = d;
    userOp_ready = 1'b1;
    @(negedge tck);
    userOp_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0) break;
      @(negedge tck);
    end
    @(negedge tck);
    check(tag, {31'b0, busy}, 32'h0);
  endtask

  int r0, c0;
  logic [31:0] a_first;

  initial begin
    // reset
    #5 trst = 1'b0;
    #40;
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_bus_req", {31'b0, bus_req}, 32'h0);
    check("rst_udi", userData_in, 32'h0);
    check("rst_bus_addr", bus_addr, 32'h0);
    @(negedge tck) trst = 1'b1;
    repeat (4) @(posedge clk);

    // single write
    r0 = n_req;
    issue(OP_SET_ADDR, 32'h0000_1000);
    issue(OP_WRITE, 32'hA5A5_0001);
    check("wr_busy_set", {31'b0, busy}, 32'h1);
    wait_idle("wr_done", 200);
    check("wr_nreq", 32'(n_req - r0), 32'd1);
    check("wr_we", {31'b0, last_we}, 32'h1);
    check("wr_addr", last_addr, 32'h0000_1000);
    check("wr_wdata", last_wdata, 32'hA5A5_0001);

    // two auto-increment reads
    r0 = n_req;
    issue(OP_SET_ADDR, 32'h0000_2000);
    slave_rdata = 32'h0000_0011;
    issue(OP_READ_INC, 32'h0);
    wait_idle("rdi1_done", 200);
    a_first = last_addr;
    check("rdi1_addr", a_first, 32'h0000_2000);
    check("rdi1_data", userData_in, 32'h0000_0011);
    slave_rdata = 32'h0000_0022;
    issue(OP_READ_INC, 32'h0);
    wait_idle("rdi2_done", 200);
    check("rdi2_addr", last_addr, 32'h0000_2004);
    check("rdi2_we", {31'b0, last_we}, 32'h0);
    check("rdi2_data", userData_in, 32'h0000_0022);
    check("rdi_nreq", 32'(n_req - r0), 32'd2);

    // overrun: second READ while busy is dropped
    r0 = n_req;
    issue(OP_READ, 32'h0);
    issue(OP_READ, 32'h0);
    wait_idle("ovr_done", 200);
    check("ovr_nreq", 32'(n_req - r0), 32'd1);
    check("ovr_addr", last_addr, 32'h0000_2008);
    issue(OP_SEL_STATUS, 32'h0);
    check("ovr_status", userData_in, 32'h0000_0002);
    issue(OP_CLR_STATUS, 32'h0);
    check("ovr_clr", userData_in, 32'h0);

    // timeout: no ack from slave
    slave_en = 1'b0;
    c0 = req_cycles;
    issue(OP_WRITE, 32'h0BAD_F00D);
    wait_idle("tmo_done", 2000);
    check("tmo_req_cycles", 32'(req_cycles - c0), 32'd255);
    check("tmo_status", userData_in, 32'h0000_0004);
    issue(OP_SEL_DATA, 32'h0);
    check("tmo_data", userData_in, 32'hDEAD_BEEF);
    slave_en = 1'b1;

    // slave error on a read
    slave_err   = 1'b1;
    slave_rdata = 32'h5555_AAAA;
    issue(OP_READ, 32'h0);
    wait_idle("err_done", 200);
    check("err_data", userData_in, 32'h5555_AAAA);
    issue(OP_SEL_STATUS, 32'h0);
    check("err_status", userData_in, 32'h0000_0004);
    issue(OP_CLR_STATUS, 32'h0);
    check("err_clr", userData_in, 32'h0);
    slave_err = 1'b0;

    // reset while a request is outstanding
    slave_en = 1'b0;
    issue(OP_WRITE, 32'hBAD0_0000);
    for (int i = 0; i < 100; i++) begin
      if (bus_req === 1'b1) break;
      @(posedge clk);
    end
    check("abort_req_seen", {31'b0, bus_req}, 32'h1);
    #3 trst = 1'b0;
    #1;
    check("abort_req_drop", {31'b0, bus_req}, 32'h0);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_udi", userData_in, 32'h0);
    #20;
    @(negedge tck) trst = 1'b1;
    repeat (4) @(posedge clk);
    slave_en = 1'b1;
    r0 = n_req;
    issue(OP_SET_ADDR, 32'h0000_3000);
    issue(OP_WRITE, 32'h1234_5678);
    wait_idle("post_rst_done", 200);
    check("post_rst_nreq", 32'(n_req - r0), 32'd1);
    check("post_rst_addr", last_addr, 32'h0000_3000);
    check("post_rst_wdata", last_wdata, 32'h1234_5678);

    // slow tck (1:7)
    tck_half = 35; clk_half = 5;
    r0 = n_req;
    issue(OP_SET_ADDR, 32'h0000_4000);
    for (int i = 0; i < 3; i++) begin
      issue(OP_WRITE_INC, 32'h100 + 32'(i));
      wait_idle("slow_tck_done", 200);
    end
    check("slow_tck_nreq", 32'(n_req - r0), 32'd3);
    check("slow_tck_addr", last_addr, 32'h0000_4008);

    // fast tck (7:1)
    tck_half = 5; clk_half = 35;
    r0 = n_req;
    for (int i = 0; i < 3; i++) begin
      issue(OP_WRITE_INC, 32'h200 + 32'(i));
      wait_idle("fast_tck_done", 400);
    end
    check("fast_tck_nreq", 32'(n_req - r0), 32'd3);
    check("fast_tck_addr", last_addr, 32'h0000_4014);
    check("fast_tck_wdata", last_wdata, 32'h0000_0202);

    // phase sweep
    tck_half = 10;
    r0 = n_req;
    for (int k = 0; k < 5; k++) begin
      clk_half = 7 + k;
      for (int j = 0; j < 2; j++) begin
        issue(OP_WRITE_INC, 32'h300 + 32'(2 * k + j));
        wait_idle("sweep_done", 300);
      end
    end
    check("sweep_nreq", 32'(n_req - r0), 32'd10);
    check("sweep_addr", last_addr, 32'h0000_403C);
    check("sweep_wdata", last_wdata, 32'h0000_0309);
    issue(OP_SEL_STATUS, 32'h0);
    check("sweep_status", userData_in, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
